// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager endpoint: single-beat Get/PutFullData/PutPartialData
// served from a local word-addressed SRAM with a registered D channel.
module tl_ul_sram_responder #(
  parameter int unsigned        ADDR_W    = 30,
  parameter int unsigned        SRC_W     = 2,
  parameter int unsigned        DEPTH     = 256,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 'h0000_4000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [3:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  input  logic              a_corrupt,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [3:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_sink,
  output logic              d_denied,
  output logic [31:0]       d_data,
  output logic              d_corrupt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  typedef logic [ADDR_W:0] span_t;
  localparam span_t SPAN = span_t'(4 * DEPTH);

  typedef enum logic {IDLE, RESP} state_e;

  state_e            state_q;
  logic [2:0]        opcode_q;
  logic [3:0]        size_q;
  logic [SRC_W-1:0]  source_q;
  logic              denied_q;
  logic              corrupt_q;
  logic              rdata_vld_q;

  logic              a_fire;
  logic              is_get;
  logic              is_put;
  logic              aligned;
  logic              in_range;
  logic              addr_ok;
  logic              get_ok;
  logic              put_ok;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rdata;
  logic              unused_a_param;

  assign unused_a_param = ^a_param;

  assign d_valid = (state_q == RESP);
  assign a_ready = !d_valid || d_ready;
  assign a_fire  = a_valid && a_ready;

  // Request decode
  assign is_get   = (a_opcode == 3'd4);
  assign is_put   = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign offset   = a_address - BASE_ADDR;
  assign in_range = (a_address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign idx      = offset[IDX_W+1:2];

  always_comb begin
    aligned = 1'b0;
    case (a_size)
      4'd0:    aligned = 1'b1;
      4'd1:    aligned = !a_address[0];
      4'd2:    aligned = (a_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign addr_ok = aligned && in_range;
  assign get_ok  = is_get && addr_ok;
  assign put_ok  = is_put && addr_ok;
  // Poisoned write data is acknowledged but never committed.
  assign wr_en   = a_fire && put_ok && !a_corrupt && !reset;
  assign rd_en   = a_fire && get_ok;

  // Byte-lane SRAM; the read captures the pre-write contents of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clock) begin
      if (wr_en && a_mask[gi]) begin
        mem_q[idx] <= a_data[gi*8 +: 8];
      end
      if (rd_en) begin
        rd_q <= mem_q[idx];
      end
    end

    assign rdata[gi*8 +: 8] = rd_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      opcode_q    <= 3'd0;
      size_q      <= 4'd0;
      source_q    <= '0;
      denied_q    <= 1'b0;
      corrupt_q   <= 1'b0;
      rdata_vld_q <= 1'b0;
    end else begin
      if (a_fire) begin
        state_q     <= RESP;
        opcode_q    <= {2'b00, is_get};
        size_q      <= a_size;
        source_q    <= a_source;
        denied_q    <= !(get_ok || put_ok);
        corrupt_q   <= is_get && !addr_ok;
        rdata_vld_q <= get_ok;
      end else if (d_valid && d_ready) begin
        state_q <= IDLE;
      end
    end
  end

  assign d_opcode  = opcode_q;
  assign d_param   = 2'b00;
  assign d_size    = size_q;
  assign d_source  = source_q;
  assign d_sink    = 1'b0;
  assign d_denied  = denied_q;
  assign d_corrupt = corrupt_q;
  assign d_data    = rdata_vld_q ? rdata : 32'd0;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Bench for tl_ul_sram_responder: directed vector table, handshake corner
// sequences, and randomized traffic against a word-array reference model.
module tb_tl_ul_sram_responder;

  localparam int          ADDR_W = 30;
  localparam int          SRC_W  = 2;
  localparam int          DEPTH  = 256;
  localparam logic [29:0] BASE   = 30'h4000;

  logic              clock;
  logic              reset;
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [3:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [3:0]        a_mask;
  logic [31:0]       a_data;
  logic              a_corrupt;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [3:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic [31:0]       d_data;
  logic              d_corrupt;

  tl_ul_sram_responder #(
    .ADDR_W(ADDR_W), .SRC_W(SRC_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data),
    .d_corrupt(d_corrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]       op;
    logic [3:0]       size;
    logic [SRC_W-1:0] src;
    logic [29:0]      addr;
    logic [3:0]       mask;
    logic [31:0]      data;
    logic             corrupt;
  } req_t;

  typedef struct {
    logic [2:0]       op;
    logic [3:0]       size;
    logic [SRC_W-1:0] src;
    logic             denied;
    logic [31:0]      data;
    logic             corrupt;
  } rsp_t;

  typedef struct {
    req_t        req;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [31:0] e_data;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_mem [DEPTH];
  logic        exp_valid;
  rsp_t        exp_rsp;
  vec_t        tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [2:0] op, input logic [3:0] size,
                              input logic [29:0] addr, input logic [3:0] mask,
                              input logic [31:0] data, input logic cor,
                              input logic [SRC_W-1:0] src);
    req_t r;
    r.op = op; r.size = size; r.addr = addr; r.mask = mask;
    r.data = data; r.corrupt = cor; r.src = src;
    return r;
  endfunction

  // Reference: legality by plain arithmetic, SRAM as a word array.
  function automatic rsp_t model(input req_t r);
    rsp_t   s;
    longint a;
    bit     legal;
    int     w;
    a = longint'(r.addr);
    legal = (r.size <= 2) && ((a % (64'd1 << r.size)) == 0) &&
            (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
    w = legal ? int'((a - longint'(BASE)) / 4) : 0;
    s.size = r.size; s.src = r.src; s.data = 32'd0; s.corrupt = 1'b0;
    if (r.op == 3'd4) begin
      s.op = 3'd1;
      s.denied = !legal;
      s.corrupt = !legal;
      if (legal) s.data = mdl_mem[w];
    end else if (r.op == 3'd0 || r.op == 3'd1) begin
      s.op = 3'd0;
      s.denied = !legal;
      if (legal && !r.corrupt) begin
        for (int b = 0; b < 4; b++)
          if (r.mask[b]) mdl_mem[w][8*b +: 8] = r.data[8*b +: 8];
      end
    end else begin
      s.op = 3'd0;
      s.denied = 1'b1;
    end
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, " d_valid"}, d_valid, exp_valid);
    if (exp_valid) begin
      chk({tag, " d_opcode"}, d_opcode, exp_rsp.op);
      chk({tag, " d_size"}, d_size, exp_rsp.size);
      chk({tag, " d_source"}, d_source, exp_rsp.src);
      chk({tag, " d_denied"}, d_denied, exp_rsp.denied);
      chk({tag, " d_data"}, d_data, exp_rsp.data);
      chk({tag, " d_corrupt"}, d_corrupt, exp_rsp.corrupt);
      chk({tag, " d_param_sink"}, {d_param, d_sink}, 3'b000);
    end
  endtask

  // One clock: drive, check a_ready, advance model, then check D outputs.
  task automatic step(input logic av, input req_t r, input logic dr, input string tag);
    logic exp_ready;
    a_valid = av; a_opcode = r.op; a_size = r.size; a_source = r.src;
    a_address = r.addr; a_mask = r.mask; a_data = r.data; a_corrupt = r.corrupt;
    a_param = 3'd0; d_ready = dr;
    #1;
    exp_ready = !exp_valid || dr;
    chk({tag, " a_ready"}, a_ready, exp_ready);
    if (av && exp_ready) begin
      exp_rsp = model(r);
      exp_valid = 1'b1;
    end else if (exp_valid && dr) begin
      exp_valid = 1'b0;
    end
    @(posedge clock); #1;
    check_outputs(tag);
  endtask

  function automatic void add_vec(input req_t r, input logic [2:0] eop,
                                  input logic eden, input logic ecor,
                                  input logic [31:0] edata);
    vec_t v;
    v.req = r; v.e_op = eop; v.e_den = eden; v.e_cor = ecor; v.e_data = edata;
    tbl.push_back(v);
  endfunction

  req_t idle_r;
  req_t rr;

  initial begin
    idle_r = mk(3'd4, 4'd2, BASE, 4'hF, 32'd0, 1'b0, '0);
    reset = 1'b1; exp_valid = 1'b0;
    a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0; d_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst d_valid", d_valid, 1'b0);
    chk("rst outs", {d_opcode, d_size, d_source, d_denied, d_corrupt}, '0);
    chk("rst d_data", d_data, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rst a_ready", a_ready, 1'b1);

    // Directed vectors: request, expected opcode/denied/corrupt/data.
    add_vec(mk(3'd0, 4'd2, 30'h4000, 4'hF, 32'hDEADBEEF, 0, 0), 3'd0, 0, 0, 32'h0);
    add_vec(mk(3'd4, 4'd2, 30'h4000, 4'hF, 32'h0,        0, 1), 3'd1, 0, 0, 32'hDEADBEEF);
    add_vec(mk(3'd0, 4'd2, 30'h4004, 4'hF, 32'hAAAAAAAA, 0, 2), 3'd0, 0, 0, 32'h0);
    add_vec(mk(3'd1, 4'd2, 30'h4004, 4'h5, 32'h11223344, 0, 3), 3'd0, 0, 0, 32'h0);
    add_vec(mk(3'd4, 4'd2, 30'h4004, 4'hF, 32'h0,        0, 0), 3'd1, 0, 0, 32'hAA22AA44);
    add_vec(mk(3'd4, 4'd2, 30'h4400, 4'hF, 32'h0,        0, 1), 3'd1, 1, 1, 32'h0);
    add_vec(mk(3'd2, 4'd2, 30'h4000, 4'hF, 32'h12345678, 0, 2), 3'd0, 1, 0, 32'h0);
    add_vec(mk(3'd4, 4'd2, 30'h4000, 4'hF, 32'h0,        0, 3), 3'd1, 0, 0, 32'hDEADBEEF);
    add_vec(mk(3'd4, 4'd2, 30'h4002, 4'hF, 32'h0,        0, 0), 3'd1, 1, 1, 32'h0);
    add_vec(mk(3'd4, 4'd1, 30'h4002, 4'h3, 32'h0,        0, 1), 3'd1, 0, 0, 32'hDEADBEEF);
    add_vec(mk(3'd4, 4'd3, 30'h4000, 4'hF, 32'h0,        0, 2), 3'd1, 1, 1, 32'h0);
    add_vec(mk(3'd0, 4'd2, 30'h4000, 4'hF, 32'h0,        1, 3), 3'd0, 0, 0, 32'h0);
    add_vec(mk(3'd4, 4'd2, 30'h4000, 4'hF, 32'h0,        0, 0), 3'd1, 0, 0, 32'hDEADBEEF);
    add_vec(mk(3'd4, 4'd2, 30'h3FFC, 4'hF, 32'h0,        0, 1), 3'd1, 1, 1, 32'h0);
    add_vec(mk(3'd0, 4'd2, 30'h43FC, 4'hF, 32'hCAFEF00D, 0, 2), 3'd0, 0, 0, 32'h0);
    add_vec(mk(3'd4, 4'd2, 30'h43FC, 4'hF, 32'h0,        0, 3), 3'd1, 0, 0, 32'hCAFEF00D);
    add_vec(mk(3'd5, 4'd2, 30'h4000, 4'hF, 32'h0,        0, 0), 3'd0, 1, 0, 32'h0);
    add_vec(mk(3'd7, 4'd2, 30'h4000, 4'hF, 32'h0,        0, 1), 3'd0, 1, 0, 32'h0);
    add_vec(mk(3'd0, 4'd2, 30'h4001, 4'hF, 32'h55555555, 0, 2), 3'd0, 1, 0, 32'h0);
    add_vec(mk(3'd4, 4'd0, 30'h4003, 4'h8, 32'h0,        0, 3), 3'd1, 0, 0, 32'hDEADBEEF);

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].req, 1'b1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d opcode", i), d_opcode, tbl[i].e_op);
      chk($sformatf("vec%0d denied", i), d_denied, tbl[i].e_den);
      chk($sformatf("vec%0d corrupt", i), d_corrupt, tbl[i].e_cor);
      chk($sformatf("vec%0d data", i), d_data, tbl[i].e_data);
    end
    step(1'b0, idle_r, 1'b1, "drain0");

    // Back-to-back Gets, one per cycle
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(3'd4, 4'd2, 30'h4004, 4'hF, 32'h0, 0, SRC_W'(i)), 1'b1, "b2b");
      chk("b2b d_source order", d_source, i);
    end
    step(1'b0, idle_r, 1'b1, "drain1");

    // Backpressure: held response, competing request must not be taken
    step(1'b1, mk(3'd4, 4'd2, 30'h4004, 4'hF, 32'h0, 0, 2), 1'b0, "stall0");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, mk(3'd0, 4'd2, 30'h4004, 4'hF, 32'h0BADF00D, 0, 1), 1'b0, "stall");
      chk("stall held data", d_data, 32'hAA22AA44);
      chk("stall held source", d_source, 2);
    end
    step(1'b1, mk(3'd4, 4'd2, 30'h4000, 4'hF, 32'h0, 0, 3), 1'b1, "stall_rel");
    chk("stall_rel new data", d_data, 32'hDEADBEEF);
    step(1'b0, idle_r, 1'b1, "drain2");

    // Reset with a response pending; a fire during reset must not write
    step(1'b1, mk(3'd4, 4'd2, 30'h4000, 4'hF, 32'h0, 0, 1), 1'b0, "rst_mid");
    reset = 1'b1;
    #1;
    chk("rst_mid d_valid", d_valid, 1'b0);
    chk("rst_mid d_data", d_data, 32'h0);
    chk("rst_mid outs", {d_opcode, d_source, d_denied, d_corrupt}, '0);
    exp_valid = 1'b0;
    a_valid = 1'b1; a_opcode = 3'd0; a_size = 4'd2; a_address = 30'h4000;
    a_mask = 4'hF; a_data = 32'h0BAD0BAD; a_corrupt = 1'b0; d_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rst_rel d_valid", d_valid, 1'b0);
    step(1'b1, mk(3'd4, 4'd2, 30'h4000, 4'hF, 32'h0, 0, 0), 1'b1, "rst_rel");
    chk("rst_rel sram kept", d_data, 32'hDEADBEEF);
    step(1'b1, mk(3'd4, 4'd2, 30'h43FC, 4'hF, 32'h0, 0, 1), 1'b1, "rst_rel2");
    chk("rst_rel2 sram kept", d_data, 32'hCAFEF00D);
    step(1'b0, idle_r, 1'b1, "drain3");

    // Fill every word so random reads have known contents
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk(3'd0, 4'd2, BASE + 30'(4 * i), 4'hF, $urandom, 0, SRC_W'(i)), 1'b1, "fill");

    // Randomized traffic with random backpressure
    for (int n = 0; n < 800; n++) begin
      int sel;
      int off;
      sel = $urandom_range(0, 9);
      rr.op = (sel < 4) ? 3'd4 : (sel < 6) ? 3'd0 : (sel < 8) ? 3'd1 :
              (sel == 8) ? 3'($urandom_range(0, 7)) : 3'd2 + 3'($urandom_range(0, 1)) * 3'd3;
      rr.size = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      off = $urandom_range(0, 4 * DEPTH - 1);
      if ($urandom_range(0, 4) != 0)
        off = (rr.size <= 2) ? (off & ~((1 << rr.size) - 1)) : (off & ~3);
      rr.addr = ($urandom_range(0, 7) == 0) ? 30'h3F00 + 30'($urandom_range(0, 'h600))
                                            : BASE + 30'(off);
      rr.mask = 4'($urandom);
      rr.data = $urandom;
      rr.corrupt = ($urandom_range(0, 9) == 0);
      rr.src = SRC_W'($urandom);
      step($urandom_range(0, 3) != 0, rr, $urandom_range(0, 3) != 0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
